// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 FFT butterfly scheduler.
// Holds the frame constants, the complex word layout, the FSM states and the bit-reversal helper.
package fft_pkg;

  localparam int FFT_N     = 16;
  localparam int FFT_LOG2N = $clog2(FFT_N);
  localparam int DW        = 64;

  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_t;

  // Reverses the low 'bits' bits of v; supports frames up to 256 points.
  function automatic logic [7:0] bitrev(input logic [7:0] v, input int bits);
    logic [7:0] r;
    r = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (i < bits) begin
        r[3'(bits - 1 - i)] = v[i];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Maps (stage, butterfly k) of an in-place DIF FFT to operand indices and twiddle index.
// Purely combinational so it can be exercised exhaustively on its own.
module fft_bf_addr_gen #(
  parameter int N     = 16,
  parameter int LOG2N = $clog2(N),
  parameter int TW_W  = LOG2N - 1,
  parameter int SW    = $clog2(LOG2N)
) (
  input  logic [SW-1:0]    i_stage,
  input  logic [TW_W-1:0]  i_k,
  output logic [LOG2N-1:0] o_idx_a,
  output logic [LOG2N-1:0] o_idx_b,
  output logic [TW_W-1:0]  o_tw
);

  localparam logic [LOG2N-1:0] HALF = LOG2N'(N / 2);

  logic [LOG2N-1:0] w_span;
  logic [LOG2N-1:0] w_mask;
  logic [LOG2N-1:0] w_k;
  logic [LOG2N-1:0] w_j;

  // span is a power of two, so k mod span and group*span are plain masks of k
  always_comb begin
    w_span  = HALF >> i_stage;
    w_mask  = w_span - LOG2N'(1);
    w_k     = {1'b0, i_k};
    w_j     = w_k & w_mask;
    o_idx_a = ((w_k & ~w_mask) << 1) | w_j;
    o_idx_b = o_idx_a | w_span;
    o_tw    = TW_W'(w_j << i_stage);
  end

endmodule

// File: rtl/fft_bf_sched.sv
// Frame buffer and sequencer for one shared radix-2 DIF butterfly: load N samples,
// run LOG2N in-place stages one butterfly at a time, stream bins out in natural order.
module fft_bf_sched
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int LOG2N = $clog2(N),
  parameter int TW_W  = LOG2N - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            bf_start,
  output logic [DW-1:0]   bf_a,
  output logic [DW-1:0]   bf_b,
  output logic [TW_W-1:0] bf_tw,
  input  logic            bf_valid,
  input  logic [DW-1:0]   bf_a_res,
  input  logic [DW-1:0]   bf_b_res,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic            busy
);

  localparam int SW = $clog2(LOG2N);

  state_t           r_state;
  logic [LOG2N-1:0] r_ld_cnt;
  logic [LOG2N-1:0] r_out_cnt;
  logic [LOG2N-1:0] r_idx_a;
  logic [LOG2N-1:0] r_idx_b;
  logic [TW_W-1:0]  r_k;
  logic [SW-1:0]    r_stage;
  cplx_t            r_buf [N];

  logic             r_in_ready;
  logic             r_bf_start;
  logic             r_busy;
  logic             r_out_valid;
  logic             r_out_last;
  logic [DW-1:0]    r_bf_a;
  logic [DW-1:0]    r_bf_b;
  logic [TW_W-1:0]  r_bf_tw;
  logic [DW-1:0]    r_out_data;

  logic             w_last_k;
  logic             w_last_stage;
  logic [SW-1:0]    w_nxt_stage;
  logic [TW_W-1:0]  w_nxt_k;
  logic [LOG2N-1:0] w_nxt_a;
  logic [LOG2N-1:0] w_nxt_b;
  logic [TW_W-1:0]  w_nxt_tw;
  logic             w_wr0_en;
  logic [LOG2N-1:0] w_wr0_addr;
  logic [DW-1:0]    w_wr0_data;
  logic             w_wr1_en;
  logic [LOG2N-1:0] w_wr1_addr;
  logic [DW-1:0]    w_wr1_data;
  logic [DW-1:0]    w_op_a;
  logic [DW-1:0]    w_op_b;
  logic [LOG2N-1:0] w_out_nxt;
  logic [LOG2N-1:0] w_out_rev;

  assign in_ready  = r_in_ready;
  assign bf_start  = r_bf_start;
  assign bf_a      = r_bf_a;
  assign bf_b      = r_bf_b;
  assign bf_tw     = r_bf_tw;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

  assign w_last_k     = (r_k == TW_W'(N / 2 - 1));
  assign w_last_stage = (r_stage == SW'(LOG2N - 1));
  assign w_out_nxt    = r_out_cnt + LOG2N'(1);
  assign w_out_rev    = LOG2N'(bitrev(8'(w_out_nxt), LOG2N));

  // Operands are read on the edge that writes back the previous result, so bypass the write ports.
  function automatic logic [DW-1:0] fwd(
    input logic [DW-1:0]    mem,
    input logic [LOG2N-1:0] idx,
    input logic             e0,
    input logic [LOG2N-1:0] a0,
    input logic [DW-1:0]    d0,
    input logic             e1,
    input logic [LOG2N-1:0] a1,
    input logic [DW-1:0]    d1
  );
    if (e1 && (a1 == idx)) begin
      return d1;
    end else if (e0 && (a0 == idx)) begin
      return d0;
    end else begin
      return mem;
    end
  endfunction

  always_comb begin
    if ((r_state == ST_WAIT) && !w_last_k) begin
      w_nxt_stage = r_stage;
      w_nxt_k     = r_k + TW_W'(1);
    end else if (r_state == ST_WAIT) begin
      w_nxt_stage = r_stage + SW'(1);
      w_nxt_k     = {TW_W{1'b0}};
    end else begin
      w_nxt_stage = {SW{1'b0}};
      w_nxt_k     = {TW_W{1'b0}};
    end
  end

  fft_bf_addr_gen #(.N(N)) u_addr_gen (
    .i_stage (w_nxt_stage),
    .i_k     (w_nxt_k),
    .o_idx_a (w_nxt_a),
    .o_idx_b (w_nxt_b),
    .o_tw    (w_nxt_tw)
  );

  always_comb begin
    w_wr0_en   = 1'b0;
    w_wr0_addr = {LOG2N{1'b0}};
    w_wr0_data = {DW{1'b0}};
    w_wr1_en   = 1'b0;
    w_wr1_addr = {LOG2N{1'b0}};
    w_wr1_data = {DW{1'b0}};
    case (r_state)
      ST_LOAD: begin
        w_wr0_en   = in_valid;
        w_wr0_addr = r_ld_cnt;
        w_wr0_data = in_data;
      end
      ST_WAIT: begin
        w_wr0_en   = bf_valid;
        w_wr0_addr = r_idx_a;
        w_wr0_data = bf_a_res;
        w_wr1_en   = bf_valid;
        w_wr1_addr = r_idx_b;
        w_wr1_data = bf_b_res;
      end
      default: begin
        w_wr0_en = 1'b0;
        w_wr1_en = 1'b0;
      end
    endcase
    w_op_a = fwd(r_buf[w_nxt_a], w_nxt_a, w_wr0_en, w_wr0_addr, w_wr0_data,
                 w_wr1_en, w_wr1_addr, w_wr1_data);
    w_op_b = fwd(r_buf[w_nxt_b], w_nxt_b, w_wr0_en, w_wr0_addr, w_wr0_data,
                 w_wr1_en, w_wr1_addr, w_wr1_data);
  end

  // Frame buffer: deliberately not reset, writes blocked while rst is high
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_wr0_en) begin
        r_buf[w_wr0_addr] <= w_wr0_data;
      end
      if (w_wr1_en) begin
        r_buf[w_wr1_addr] <= w_wr1_data;
      end
    end
  end

  // Sequencer FSM with registered handshake and datapath outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_ld_cnt    <= {LOG2N{1'b0}};
      r_out_cnt   <= {LOG2N{1'b0}};
      r_idx_a     <= {LOG2N{1'b0}};
      r_idx_b     <= {LOG2N{1'b0}};
      r_k         <= {TW_W{1'b0}};
      r_stage     <= {SW{1'b0}};
      r_in_ready  <= 1'b1;
      r_bf_start  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_bf_a      <= {DW{1'b0}};
      r_bf_b      <= {DW{1'b0}};
      r_bf_tw     <= {TW_W{1'b0}};
      r_out_data  <= {DW{1'b0}};
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (in_valid) begin
            r_ld_cnt <= r_ld_cnt + LOG2N'(1);
            if (r_ld_cnt == LOG2N'(N - 1)) begin
              r_state    <= ST_ISSUE;
              r_ld_cnt   <= {LOG2N{1'b0}};
              r_stage    <= {SW{1'b0}};
              r_k        <= {TW_W{1'b0}};
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_bf_start <= 1'b1;
              r_bf_a     <= w_op_a;
              r_bf_b     <= w_op_b;
              r_bf_tw    <= w_nxt_tw;
              r_idx_a    <= w_nxt_a;
              r_idx_b    <= w_nxt_b;
            end
          end
        end
        ST_ISSUE: begin
          r_bf_start <= 1'b0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bf_valid) begin
            if (w_last_k && w_last_stage) begin
              // final butterfly touches N-2/N-1, so bin 0 (buf[0]) is already settled
              r_state     <= ST_UNLOAD;
              r_busy      <= 1'b0;
              r_out_cnt   <= {LOG2N{1'b0}};
              r_out_valid <= 1'b1;
              r_out_data  <= r_buf[0];
              r_out_last  <= 1'b0;
            end else begin
              r_state    <= ST_ISSUE;
              r_stage    <= w_nxt_stage;
              r_k        <= w_nxt_k;
              r_bf_start <= 1'b1;
              r_bf_a     <= w_op_a;
              r_bf_b     <= w_op_b;
              r_bf_tw    <= w_nxt_tw;
              r_idx_a    <= w_nxt_a;
              r_idx_b    <= w_nxt_b;
            end
          end
        end
        ST_UNLOAD: begin
          if (out_ready) begin
            if (r_out_cnt == LOG2N'(N - 1)) begin
              r_state     <= ST_LOAD;
              r_out_cnt   <= {LOG2N{1'b0}};
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_in_ready  <= 1'b1;
            end else begin
              r_out_cnt  <= w_out_nxt;
              r_out_data <= r_buf[w_out_rev];
              r_out_last <= (w_out_nxt == LOG2N'(N - 1));
            end
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_bf_sched.sv
// Directed/random bench for fft_bf_sched with a loop-based DIF FFT reference and butterfly responder.
module tb_fft_bf_sched;

  localparam int N     = 16;
  localparam int LOG2N = 4;
  localparam int NBF   = (N / 2) * LOG2N;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        bf_start;
  logic [63:0] bf_a;
  logic [63:0] bf_b;
  logic [2:0]  bf_tw;
  logic        bf_valid;
  logic [63:0] bf_a_res;
  logic [63:0] bf_b_res;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] tw_tab  [N/2];
  logic [63:0] x       [N];
  logic [63:0] exp_out [N];
  logic [63:0] exp_a   [NBF];
  logic [63:0] exp_b   [NBF];
  int          exp_tw  [NBF];

  fft_bf_sched #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bf_start(bf_start), .bf_a(bf_a), .bf_b(bf_b), .bf_tw(bf_tw),
    .bf_valid(bf_valid), .bf_a_res(bf_a_res), .bf_b_res(bf_b_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] cadd(input logic [63:0] a, input logic [63:0] b);
    return {a[63:32] + b[63:32], a[31:0] + b[31:0]};
  endfunction

  function automatic logic [63:0] bf_bo(input logic [63:0] a, input logic [63:0] b, input int tw);
    logic signed [31:0] dr, di, wr, wi;
    longint pr, pi;
    dr = a[63:32] - b[63:32];
    di = a[31:0] - b[31:0];
    wr = tw_tab[tw][63:32];
    wi = tw_tab[tw][31:0];
    pr = (longint'(dr) * longint'(wr) - longint'(di) * longint'(wi)) >>> 16;
    pi = (longint'(dr) * longint'(wi) + longint'(di) * longint'(wr)) >>> 16;
    return {pr[31:0], pi[31:0]};
  endfunction

  // Textbook in-place DIF FFT over groups/offsets, recording each butterfly in issue order.
  task automatic build_model;
    logic [63:0] m [N];
    logic [63:0] na, nb;
    int n, span, ia, ib, t, r;
    for (int i = 0; i < N; i++) m[i] = x[i];
    n = 0;
    for (int s = 0; s < LOG2N; s++) begin
      span = (N / 2) >> s;
      for (int grp = 0; grp < N / (2 * span); grp++) begin
        for (int j = 0; j < span; j++) begin
          ia = grp * 2 * span + j;
          ib = ia + span;
          t  = j << s;
          exp_a[n] = m[ia];
          exp_b[n] = m[ib];
          exp_tw[n] = t;
          na = cadd(m[ia], m[ib]);
          nb = bf_bo(m[ia], m[ib], t);
          m[ia] = na;
          m[ib] = nb;
          n++;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      r = 0;
      for (int bt = 0; bt < LOG2N; bt++) if (((i >> bt) & 1) == 1) r |= 1 << (LOG2N - 1 - bt);
      exp_out[i] = m[r];
    end
  endtask

  task automatic run_frame(input int lat, input bit spur, input logic [3:0] rdy_pat, input int abort_at);
    int t, cyc, i, p, guard;
    build_model();
    for (int s = 0; s < N; s++) begin
      in_valid = 1'b1;
      in_data  = x[s];
      if (spur && s == 0) begin
        bf_valid = 1'b1;
        bf_a_res = {$urandom, $urandom};
        bf_b_res = {$urandom, $urandom};
      end
      check("load_in_ready", 64'(in_ready), 64'd1);
      tick();
      bf_valid = 1'b0;
    end
    in_valid = spur;
    in_data  = {$urandom, $urandom};
    cyc = 0;
    for (int b = 0; b < NBF; b++) begin
      t = 0;
      while (bf_start !== 1'b1 && t < 20) begin
        tick();
        t++;
        cyc++;
      end
      check("bf_start", 64'(bf_start), 64'd1);
      check("busy_issue", 64'(busy), 64'd1);
      check("in_ready_busy", 64'(in_ready), 64'd0);
      check("bf_a", bf_a, exp_a[b]);
      check("bf_b", bf_b, exp_b[b]);
      check("bf_tw", 64'(bf_tw), 64'(exp_tw[b]));
      if (spur) begin
        bf_valid = 1'b1;
        bf_a_res = {$urandom, $urandom};
        bf_b_res = {$urandom, $urandom};
      end
      tick();
      cyc++;
      bf_valid = 1'b0;
      check("bf_start_pulse", 64'(bf_start), 64'd0);
      if (b == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_bf_start", 64'(bf_start), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        bf_valid = 1'b1;
        bf_a_res = {$urandom, $urandom};
        bf_b_res = {$urandom, $urandom};
        tick();
        bf_valid = 1'b0;
        check("late_bf_in_ready", 64'(in_ready), 64'd1);
        check("late_bf_start", 64'(bf_start), 64'd0);
        check("late_bf_busy", 64'(busy), 64'd0);
        return;
      end
      for (int w = 1; w < lat; w++) begin
        tick();
        cyc++;
      end
      check("bf_a_hold", bf_a, exp_a[b]);
      check("bf_tw_hold", 64'(bf_tw), 64'(exp_tw[b]));
      bf_valid = 1'b1;
      bf_a_res = cadd(exp_a[b], exp_b[b]);
      bf_b_res = bf_bo(exp_a[b], exp_b[b], exp_tw[b]);
      tick();
      cyc++;
      bf_valid = 1'b0;
    end
    in_valid = 1'b0;
    if (lat == 1) check("compute_cycles", 64'(cyc), 64'(NBF * 2));
    check("busy_unload", 64'(busy), 64'd0);
    i = 0;
    p = 0;
    guard = 0;
    while (i < N && guard < 200) begin
      out_ready = rdy_pat[p % 4];
      check("out_valid", 64'(out_valid), 64'd1);
      check("out_data", out_data, exp_out[i]);
      check("out_last", 64'(out_last), 64'(i == N - 1));
      tick();
      if (out_ready) i++;
      p++;
      guard++;
    end
    out_ready = 1'b0;
    check("bins_sent", 64'(i), 64'(N));
    check("done_out_valid", 64'(out_valid), 64'd0);
    check("done_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic fill_random;
    int re, im;
    for (int i = 0; i < N; i++) begin
      re = int'($urandom_range(0, 32'h1FFFFF)) - 1048576;
      im = int'($urandom_range(0, 32'h1FFFFF)) - 1048576;
      x[i] = {re[31:0], im[31:0]};
    end
  endtask

  task automatic fill_const(input logic [63:0] first, input logic [63:0] rest);
    for (int i = 0; i < N; i++) x[i] = (i == 0) ? first : rest;
  endtask

  initial begin
    for (int k = 0; k < N / 2; k++) begin
      int wr, wi;
      wr = int'($cos(2.0 * 3.14159265358979 * k / N) * 65536.0);
      wi = int'(-$sin(2.0 * 3.14159265358979 * k / N) * 65536.0);
      tw_tab[k] = {wr[31:0], wi[31:0]};
    end
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 64'd0;
    bf_valid = 1'b0;
    bf_a_res = 64'd0;
    bf_b_res = 64'd0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_bf_start", 64'(bf_start), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_bf_tw", 64'(bf_tw), 64'd0);
    check("rst_bf_a", bf_a, 64'd0);
    check("rst_bf_b", bf_b, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    rst = 1'b0;
    tick();

    fill_random();
    run_frame(1, 1'b0, 4'b1111, -1);
    run_frame(5, 1'b1, 4'b1111, -1);
    fill_const(64'h00010000_00000000, 64'd0);
    run_frame(1, 1'b0, 4'b1001, -1);
    fill_const(64'h00010000_00000000, 64'h00010000_00000000);
    run_frame(2, 1'b0, 4'b1001, -1);
    fill_const(64'h00010000_00000000, 64'd0);
    run_frame(1, 1'b0, 4'b1111, 17);
    run_frame(1, 1'b0, 4'b1111, -1);
    fill_random();
    run_frame(3, 1'b1, 4'b1011, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_bf_sched.md
Name: fft_bf_sched

Overview:
- Sequencing controller for a single shared radix-2 butterfly unit. The butterfly computes a_o = a+b and b_o = (a−b)·W^k.
- Collects one frame of N complex samples into an internal buffer.
- Runs log2(N) decimation-in-frequency stages, issuing one butterfly at a time and writing results back in place.
- Streams the finished spectrum out in natural order. Sits between the audio sample front-end and the spectral effector stage.

Parameters:
N, 16, FFT size; power of two, 4..64.
LOG2N, $clog2(N), derived; number of stages and index width.
DW, 64, complex word width: [63:32] real, [31:0] imag, each signed 16.16 fixed point.
TW_W, LOG2N-1, twiddle index width (k in 0..N/2-1).

Ports:
clk  in  1  system clock
rst  in  1  reset
in_valid  in  1  input sample valid
in_ready  out  1  controller can accept a sample
in_data  in  DW  input complex sample
bf_start  out  1  one-cycle pulse: butterfly operands valid
bf_a  out  DW  butterfly operand a (buf[idx_a])
bf_b  out  DW  butterfly operand b (buf[idx_b])
bf_tw  out  TW_W  twiddle index k
bf_valid  in  1  butterfly results valid
bf_a_res  in  DW  result for idx_a
bf_b_res  in  DW  result for idx_b
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output
out_data  out  DW  output spectrum bin
out_last  out  1  asserted with bin N-1
busy  out  1  high in ISSUE/WAIT

Behaviour:
- Clocking/reset (already decided): one clock, clk; reset rst is synchronous, active-high.
- Reset values:
  - State LOAD; all counters 0.
  - in_ready=1 from the first cycle after reset; all other outputs 0 (bf_start, out_valid, out_last, busy, bf_tw, bf_a, bf_b, out_data).
  - Buffer contents are not reset.
- States: LOAD, ISSUE, WAIT, UNLOAD.
- LOAD:
  - in_ready=1.
  - On in_valid: buf[ld_cnt] <= in_data, ld_cnt++.
  - When sample N-1 is accepted: go to ISSUE with stage=0, k=0.
- Index generation, for stage s and butterfly k in 0..N/2-1:
  - span = (N/2)>>s; j = k mod span; grp = k / span.
  - idx_a = grp·2·span + j; idx_b = idx_a + span.
  - bf_tw = j<<s.
- ISSUE:
  - Exactly one cycle, then WAIT.
  - bf_start=1; bf_a, bf_b, bf_tw driven registered.
  - bf_a, bf_b and bf_tw hold their values through WAIT.
- WAIT:
  - bf_start=0.
  - On bf_valid: buf[idx_a] <= bf_a_res; buf[idx_b] <= bf_b_res.
  - If k<N/2-1: k++ and go to ISSUE.
  - Else if stage<LOG2N-1: k=0, stage++, go to ISSUE.
  - Else go to UNLOAD with out_cnt=0.
  - Butterfly latency is unbounded; one butterfly is outstanding at most.
- Operand timing: write-back is visible to the next ISSUE, one cycle later; no read-before-write hazard is allowed.
- bf_valid outside WAIT is ignored, with no state or buffer change.
- Total compute: 2 cycles per butterfly at 1-cycle butterfly latency → (N/2)·LOG2N·2 cycles, i.e. 64 cycles for N=16.
- UNLOAD:
  - out_valid=1; out_data = buf[bitrev(out_cnt)] (registered, valid in the same cycle as out_valid).
  - out_last=1 when out_cnt=N-1.
  - On out_ready: out_cnt++ and present the next bin the following cycle.
  - After bin N-1 handshakes: go to LOAD, out_valid=0, in_ready=1 on the next cycle.
- AXI-style stall rule: out_data/out_last must be stable while out_valid && !out_ready.
- in_valid outside LOAD: in_ready=0; the sample is not consumed.
- rst mid-operation, in any state: on the next edge return to LOAD with counters cleared, bf_start=0, out_valid=0. An in-flight butterfly result arriving later is ignored.
- Arithmetic: no arithmetic in the controller; scaling and rounding belong to the butterfly.

Decomposition:
- Shared package fft_pkg:
  - cplx_t, a packed struct {logic signed [31:0] re, im} of width DW.
  - The state enum.
  - N/LOG2N constants.
  - A bitrev function.
- One natural sub-module, fft_bf_addr_gen: combinational (stage,k) → (idx_a, idx_b, tw). Kept separate so it can be unit-tested exhaustively.

Test Plan:
- Index order (N=16, ideal 1-cycle butterfly model):
  - Stage 0: pairs (0,8)…(7,15) with tw 0..7.
  - Stage 1: (0,4),(1,5),(2,6),(3,7),(8,12)… with tw 0,2,4,6,0,2,4,6.
  - Stage 3: (0,1),(2,3)… with tw all 0.
  - 32 bf_start pulses total.
- Impulse: in_data[0]=64'h00010000_00000000, others 0, reference butterfly → all 16 outputs 64'h00010000_00000000; out_last only on the 16th.
- DC: all inputs 64'h00010000_00000000 → bin0 = 64'h00100000_00000000, bins 1..15 = 0.
- Output backpressure: out_ready toggled 1,0,0,1 → out_data stable during stalls, no bins lost/duplicated, then in_ready=1.
- Butterfly latency 5 cycles, plus a spurious bf_valid during ISSUE and LOAD → identical results to latency-1 run; spurious pulses ignored.
- rst asserted in WAIT at stage 2 → next cycle in_ready=1, busy=0, bf_start=0, out_valid=0. Late bf_valid ignored. A fresh impulse frame then produces correct output.
